// File: rtl/aes_pkg.sv
// Shared types and constants for AES core arbitration.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package aes_pkg;

   // Width of one AES block in bits.
   localparam int AES_BLOCK_W = 128;

   // Default number of RUN cycles allowed before an in-flight block is aborted.
   localparam int AES_DEFAULT_TIMEOUT = 64;

   // Arbiter sequencing states.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOAD    = 2'd1,
      RUN     = 2'd2,
      RESPOND = 2'd3
   } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin selector: first set request bit searching upward from ptr+1 (mod N).
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
module rr_pick
   import aes_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          vld,
   output logic [IW-1:0] idx
);

   // Walk candidate offsets 1..N after the pointer; the first requesting candidate wins.
   always_comb begin
      vld = 1'b0;
      idx = '0;
      for (int k = 0; k < N; k++) begin
         for (int j = 0; j < N; j++) begin
            if (!vld && req[j] && (j == ((int'(ptr) + 1 + k) % N))) begin
               vld = 1'b1;
               idx = IW'(j);
            end
         end
      end
   end

endmodule

// File: rtl/aes_core_arbiter.sv
// Round-robin sharing of one AES-128 core between NUM_REQ requesters.
// Latency: req_valid -> req_ready 1 cycle, core_enable the cycle after, resp_valid 1 cycle after core_done.
// Backpressure: resp_valid/resp_data hold until resp_ready of the owner; no new grant meanwhile.
module aes_core_arbiter
   import aes_pkg::*;
#(
   parameter int  NUM_REQ        = 4,
   parameter int  BLOCK_W        = AES_BLOCK_W,
   parameter int  TIMEOUT_CYCLES = AES_DEFAULT_TIMEOUT,
   localparam int IDW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
   localparam int TW             = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1
) (
   input  logic                       clk,
   input  logic                       n_rst,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*BLOCK_W-1:0] req_data,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic [NUM_REQ-1:0]         resp_valid,
   input  logic [NUM_REQ-1:0]         resp_ready,
   output logic [BLOCK_W-1:0]         resp_data,
   output logic                       core_enable,
   output logic [BLOCK_W-1:0]         core_data_in,
   input  logic                       core_done,
   input  logic [BLOCK_W-1:0]         core_data_out,
   output logic [IDW-1:0]             grant_id,
   output logic                       busy,
   output logic                       timeout_err
);

   arb_state_t           state;
   arb_state_t           state_nxt;
   logic [IDW-1:0]       rr_ptr;
   logic                 pick_vld;
   logic [IDW-1:0]       pick_idx;
   logic [BLOCK_W-1:0]   data_reg;
   logic [BLOCK_W-1:0]   result_reg;
   logic [TW-1:0]        timer;
   logic [BLOCK_W-1:0]   sel_data;
   logic                 sel_valid;
   logic                 sel_resp_ready;
   logic [NUM_REQ-1:0]   grant_oh;
   logic                 run_timeout;

   rr_pick #(
      .N  (NUM_REQ),
      .IW (IDW)
   ) u_pick (
      .req (req_valid),
      .ptr (rr_ptr),
      .vld (pick_vld),
      .idx (pick_idx)
   );

   // Last RUN cycle before abort; core_done in this same cycle still takes priority.
   assign run_timeout = (timer == TW'(TIMEOUT_CYCLES - 1));

   // Route the current owner's request lane, response accept and one-hot mask.
   always_comb begin
      sel_data       = '0;
      sel_valid      = 1'b0;
      sel_resp_ready = 1'b0;
      grant_oh       = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_id == IDW'(i)) begin
            sel_data       = req_data[i*BLOCK_W +: BLOCK_W];
            sel_valid      = req_valid[i];
            sel_resp_ready = resp_ready[i];
            grant_oh[i]    = 1'b1;
         end
      end
   end

   // State register; reset abandons any block in flight.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decision for the grant / load / run / respond sequence.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (pick_vld) begin
               state_nxt = LOAD;
            end
         end
         LOAD: begin
            // A requester that withdrew during its accept cycle forfeits the turn.
            state_nxt = sel_valid ? RUN : IDLE;
         end
         RUN: begin
            if (core_done) begin
               state_nxt = RESPOND;
            end else if (run_timeout) begin
               state_nxt = IDLE;
            end
         end
         RESPOND: begin
            if (sel_resp_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs are decoded from state so that all buses read zero outside their owning state.
   always_comb begin
      req_ready    = '0;
      resp_valid   = '0;
      resp_data    = '0;
      core_enable  = 1'b0;
      core_data_in = '0;
      timeout_err  = 1'b0;
      busy         = (state != IDLE);
      case (state)
         LOAD: begin
            req_ready = grant_oh;
         end
         RUN: begin
            core_enable  = 1'b1;
            core_data_in = data_reg;
            timeout_err  = run_timeout && !core_done;
         end
         RESPOND: begin
            resp_valid = grant_oh;
            resp_data  = result_reg;
         end
         default: begin
         end
      endcase
   end

   // Ownership: capture the winner on leaving IDLE, advance the pointer only on completion or abort.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         grant_id <= '0;
         rr_ptr   <= IDW'(NUM_REQ - 1);
      end else begin
         case (state)
            IDLE: begin
               if (pick_vld) begin
                  grant_id <= pick_idx;
               end
            end
            RUN: begin
               if (!core_done && run_timeout) begin
                  rr_ptr <= grant_id;
               end
            end
            RESPOND: begin
               if (sel_resp_ready) begin
                  rr_ptr <= grant_id;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Block datapath: plaintext captured on accept, ciphertext captured on core_done.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         data_reg   <= '0;
         result_reg <= '0;
      end else begin
         if (state == LOAD && sel_valid) begin
            data_reg <= sel_data;
         end
         if (state == RUN && core_done) begin
            result_reg <= core_data_out;
         end
      end
   end

   // RUN watchdog: cleared on accept, counts every cycle the core is enabled.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         timer <= '0;
      end else if (state == LOAD) begin
         timer <= '0;
      end else if (state == RUN) begin
         timer <= timer + TW'(1);
      end
   end

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Testbench for aes_core_arbiter: AES core model, round-robin reference model, directed + random transactions.
// Latency: n/a.
// Backpressure: exercised by holding resp_ready low on the owner.
module tb_aes_core_arbiter;

   localparam int N  = 4;
   localparam int W  = 128;
   localparam int TO = 64;
   localparam int IW = 2;
   localparam logic [127:0] KEY    = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] VEC_PT = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] VEC_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic            clk;
   logic            n_rst;
   logic [N-1:0]    req_valid;
   logic [N*W-1:0]  req_data;
   logic [N-1:0]    req_ready;
   logic [N-1:0]    resp_valid;
   logic [N-1:0]    resp_ready;
   logic [W-1:0]    resp_data;
   logic            core_enable;
   logic [W-1:0]    core_data_in;
   logic            core_done;
   logic [W-1:0]    core_data_out;
   logic [IW-1:0]   grant_id;
   logic            busy;
   logic            timeout_err;

   int checks = 0;
   int errors = 0;
   int core_lat = 1;
   int m_ptr;
   int overlap_cnt = 0;
   int bus_cnt = 0;
   int gap_cnt = 0;
   logic [W-1:0] pts [N];

   aes_core_arbiter #(
      .NUM_REQ        (N),
      .BLOCK_W        (W),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk           (clk),
      .n_rst         (n_rst),
      .req_valid     (req_valid),
      .req_data      (req_data),
      .req_ready     (req_ready),
      .resp_valid    (resp_valid),
      .resp_ready    (resp_ready),
      .resp_data     (resp_data),
      .core_enable   (core_enable),
      .core_data_in  (core_data_in),
      .core_done     (core_done),
      .core_data_out (core_data_out),
      .grant_id      (grant_id),
      .busy          (busy),
      .timeout_err   (timeout_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- AES-128 reference (FIPS-197) ----------------
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa, bb;
      p = 8'h00; aa = a; bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = xtime(aa);
         bb = bb >> 1;
      end
      return p;
   endfunction

   // S-box from the GF(2^8) inverse (x^254) followed by the affine map.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] sq, b;
      sq = x; b = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq = gmul(sq, sq);
         b  = gmul(b, sq);
      end
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [127:0] aes128(input logic [127:0] pt, input logic [127:0] key);
      logic [31:0]  kw [44];
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [31:0]  tmp;
      logic [7:0]   rc;
      logic [127:0] res;
      for (int i = 0; i < 4; i++) kw[i] = key[127-32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         tmp = kw[i-1];
         if (i % 4 == 0) begin
            tmp = {sbox(tmp[23:16]), sbox(tmp[15:8]), sbox(tmp[7:0]), sbox(tmp[31:24])} ^ {rc, 24'h0};
            rc  = xtime(rc);
         end
         kw[i] = kw[i-4] ^ tmp;
      end
      for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ kw[k/4][31-8*(k%4) -: 8];
      for (int r = 1; r <= 10; r++) begin
         // SubBytes + ShiftRows: byte (row, col) takes old byte (row, col+row).
         for (int k = 0; k < 16; k++) t[k] = sbox(s[(((k/4) + (k%4)) % 4) * 4 + (k%4)]);
         for (int c = 0; c < 4; c++) begin
            if (r < 10) begin
               s[4*c]   = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
               s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
               s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
               s[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
            end else begin
               for (int q = 0; q < 4; q++) s[4*c+q] = t[4*c+q];
            end
         end
         for (int k = 0; k < 16; k++) s[k] = s[k] ^ kw[4*r + k/4][31-8*(k%4) -: 8];
      end
      for (int k = 0; k < 16; k++) res[127-8*k -: 8] = s[k];
      return res;
   endfunction

   // ---------------- round-robin reference ----------------
   function automatic int model_pick(input logic [N-1:0] pat, input int ptr);
      int c;
      for (int k = 1; k <= N; k++) begin
         c = (ptr + k) % N;
         if (pat[c[IW-1:0]]) return c;
      end
      return -1;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic new_data();
      for (int i = 0; i < N; i++) pts[i] = {$urandom, $urandom, $urandom, $urandom};
      req_data = {pts[3], pts[2], pts[1], pts[0]};
   endtask

   // Core model: done pulses in the core_lat-th enabled cycle (never when core_lat is 0).
   initial begin
      int run_cnt;
      run_cnt = 0;
      core_done = 1'b0;
      core_data_out = '0;
      forever begin
         @(negedge clk);
         if (core_enable) begin
            run_cnt++;
            if (run_cnt == core_lat) begin
               core_done = 1'b1;
               core_data_out = aes128(core_data_in, KEY);
            end else begin
               core_done = 1'b0;
            end
         end else begin
            run_cnt = 0;
            core_done = 1'b0;
         end
      end
   end

   // Bus-rule monitor: ownership one-hot/exclusive, idle buses zero, core_enable gap >= 2.
   initial begin
      int low_len;
      bit had_high;
      low_len = 0;
      had_high = 1'b0;
      forever begin
         step();
         if (req_ready != '0 && resp_valid != '0) overlap_cnt++;
         if ($countones(req_ready) > 1 || $countones(resp_valid) > 1) overlap_cnt++;
         if (!core_enable && core_data_in != '0) bus_cnt++;
         if (resp_valid == '0 && resp_data != '0) bus_cnt++;
         if (core_enable) begin
            if (had_high && low_len > 0 && low_len < 2) gap_cnt++;
            had_high = 1'b1;
            low_len = 0;
         end else begin
            low_len++;
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: observed no finish by %0t, expected finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

   // One full transaction from IDLE through response acceptance.
   task automatic txn(input logic [N-1:0] pat, input int lat, input int hold,
                      input bit use_vec, input string tag);
      int w, n;
      logic [N-1:0] oh;
      logic [127:0] pt, ct;
      bit stable, saw_to;
      w = model_pick(pat, m_ptr);
      oh = '0;
      oh[w[IW-1:0]] = 1'b1;
      new_data();
      if (use_vec) begin
         pts[w[IW-1:0]] = VEC_PT;
         req_data = {pts[3], pts[2], pts[1], pts[0]};
      end
      req_valid = pat;
      core_lat = lat;
      resp_ready = '0;
      n = 0;
      do begin step(); n++; end while (req_ready == '0 && n < 4);
      chk({tag, " req_ready"}, req_ready, oh);
      chk({tag, " grant_id"}, grant_id, w);
      chk({tag, " accept latency"}, n, 1);
      pt = pts[w[IW-1:0]];
      ct = use_vec ? VEC_CT : aes128(pt, KEY);
      step();
      req_valid[w[IW-1:0]] = 1'b0;
      chk({tag, " core_enable+data"}, {core_enable, core_data_in}, {1'b1, pt});
      n = 0;
      saw_to = 1'b0;
      while (resp_valid == '0 && n < lat + 8) begin
         saw_to |= timeout_err;
         step();
         n++;
      end
      chk({tag, " done->resp latency"}, n, lat);
      chk({tag, " resp_valid"}, resp_valid, oh);
      chk({tag, " resp_data"}, resp_data, ct);
      chk({tag, " no timeout"}, saw_to, 0);
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
         resp_ready = N'($urandom) & ~oh;
         step();
         if (resp_valid !== oh || resp_data !== ct || core_enable !== 1'b0 || req_ready !== '0)
            stable = 1'b0;
      end
      chk({tag, " stable under backpressure"}, stable, 1);
      resp_ready = oh;
      step();
      resp_ready = '0;
      req_valid = '0;
      chk({tag, " idle after accept"}, {busy, resp_valid, core_enable}, 0);
      m_ptr = w;
   endtask

   initial begin
      logic [N-1:0] oh;
      int w, n;
      bit saw_resp;
      n_rst = 1'b1;
      req_valid = '0;
      req_data = '0;
      resp_ready = '0;
      m_ptr = N - 1;
      #2 n_rst = 1'b0;
      #1;
      chk("reset ctrl", {req_ready, resp_valid, core_enable, busy, timeout_err, grant_id}, 0);
      chk("reset buses", {core_data_in, resp_data}, 0);
      step();
      step();
      n_rst = 1'b1;

      // Known-answer block with all requesters contending from reset: 0,1,2,3,0.
      txn(4'b1111, 3, 2, 1'b1, "kat");
      txn(4'b1111, 2, 0, 1'b0, "rr1");
      txn(4'b1111, 5, 1, 1'b0, "rr2");
      txn(4'b1111, 1, 0, 1'b0, "rr3");
      txn(4'b1111, 4, 0, 1'b0, "rr0");
      txn(4'b1100, 2, 0, 1'b0, "pair2");
      txn(4'b1100, 2, 0, 1'b0, "pair3");

      // Long backpressure on requester 1.
      txn(4'b0010, 2, 20, 1'b0, "bp");

      // Withdraw during LOAD: no RUN, pointer untouched.
      w = model_pick(4'b0100, m_ptr);
      oh = '0;
      oh[w[IW-1:0]] = 1'b1;
      req_valid = 4'b0100;
      step();
      chk("withdraw req_ready", req_ready, oh);
      req_valid = '0;
      step();
      chk("withdraw back to idle", {busy, core_enable}, 0);
      step();
      chk("withdraw stays idle", {busy, req_ready}, 0);
      txn(4'b1100, 3, 0, 1'b0, "after_withdraw");

      // Core never finishes: abort exactly at the 64th RUN cycle.
      w = model_pick(4'b1111, m_ptr);
      oh = '0;
      oh[w[IW-1:0]] = 1'b1;
      new_data();
      req_valid = 4'b1111;
      core_lat = 0;
      step();
      chk("timeout req_ready", req_ready, oh);
      step();
      req_valid = '0;
      n = 1;
      saw_resp = 1'b0;
      while (!timeout_err && n < TO + 10) begin
         step();
         n++;
         saw_resp |= (resp_valid != '0);
      end
      chk("timeout cycle", n, TO);
      step();
      chk("timeout drop", {busy, resp_valid, timeout_err, saw_resp}, 0);
      m_ptr = w;
      txn(4'b1111, 2, 0, 1'b0, "after_timeout");
      txn(4'b0010, TO, 1, 1'b0, "done_at_limit");

      // Reset while a block is running.
      req_valid = 4'b0100;
      core_lat = 0;
      step();
      step();
      req_valid = '0;
      repeat (3) step();
      chk("midrun busy", {busy, core_enable}, 2'b11);
      n_rst = 1'b0;
      #1;
      chk("midrun reset ctrl", {req_ready, resp_valid, core_enable, busy, timeout_err, grant_id}, 0);
      chk("midrun reset buses", {core_data_in, resp_data}, 0);
      step();
      n_rst = 1'b1;
      m_ptr = N - 1;
      saw_resp = 1'b0;
      repeat (5) begin
         step();
         saw_resp |= (resp_valid != '0) || busy;
      end
      chk("no response after reset", saw_resp, 0);
      txn(4'b1111, 2, 0, 1'b0, "after_reset");

      // Randomised traffic against the reference model.
      for (int t = 0; t < 25; t++) begin
         txn(N'($urandom_range(1, 15)), $urandom_range(1, 8), $urandom_range(0, 4), 1'b0, "rand");
      end

      chk("ownership one-hot/exclusive", overlap_cnt, 0);
      chk("idle buses zero", bus_cnt, 0);
      chk("core_enable gap", gap_cnt, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/aes_core_arbiter.md
Name: aes_core_arbiter

Overview:
Shares one AES-128 encryption core between NUM_REQ independent requesters using round-robin arbitration.
- Accepts a 128-bit plaintext block from the granted requester over a valid/ready handshake.
- Sequences the core's enable/done interface and returns the ciphertext to the same requester over a valid/ready handshake.
- Sits between the system-side block sources and the encryption controller/datapath.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
BLOCK_W, 128, AES block width in bits
TIMEOUT_CYCLES, 64, max cycles in RUN waiting for core_done before abort

Ports:
clk  in  1  clock
n_rst  in  1  reset, asynchronous, active-low
req_valid  in  NUM_REQ  per-requester plaintext valid
req_data  in  NUM_REQ*BLOCK_W  packed plaintext; requester i at bits [i*BLOCK_W +: BLOCK_W]
req_ready  out  NUM_REQ  one-hot accept strobe
resp_valid  out  NUM_REQ  one-hot ciphertext valid
resp_ready  in  NUM_REQ  per-requester ciphertext accept
resp_data  out  BLOCK_W  ciphertext, shared bus
core_enable  out  1  encrypt enable to core, level
core_data_in  out  BLOCK_W  plaintext to core
core_done  in  1  core result valid, single-cycle pulse
core_data_out  in  BLOCK_W  core ciphertext
grant_id  out  $clog2(NUM_REQ)  index of current owner
busy  out  1  high in every state except IDLE
timeout_err  out  1  one-cycle pulse on abort

Behaviour:
- Reset: all of the following return to the listed values regardless of state.
  - state=IDLE; all outputs 0; grant_id=0.
  - rr_ptr=NUM_REQ-1, so requester 0 has highest priority first.
  - data_reg=0, result_reg=0, timer=0.
- FSM states: IDLE, LOAD, RUN, RESPOND.
- IDLE:
  - If any req_valid is high, pick the first set bit searching upward from rr_ptr+1 (mod NUM_REQ).
  - Register the winner into grant_id and go to LOAD.
  - Otherwise stay in IDLE. Winner selection is combinational.
- LOAD:
  - req_ready[grant_id]=1 for exactly this cycle.
  - If req_valid[grant_id]=1: data_reg<=req_data slice, timer<=0, go RUN.
  - If req_valid[grant_id]=0 (withdrawn): go IDLE with rr_ptr unchanged and no response.
- RUN:
  - core_enable=1 and core_data_in=data_reg, held steady throughout; timer increments each cycle.
  - On core_done: result_reg<=core_data_out, go RESPOND.
  - If timer==TIMEOUT_CYCLES-1 and no core_done: pulse timeout_err, rr_ptr<=grant_id, go IDLE, drop the block.
  - If core_done and timeout occur in the same cycle, core_done wins.
- RESPOND:
  - core_enable=0; resp_valid[grant_id]=1; resp_data=result_reg, stable until accepted.
  - When resp_ready[grant_id]=1: rr_ptr<=grant_id, go IDLE.
  - resp_ready of non-granted requesters is ignored.
- Latency:
  - req_valid high in IDLE -> req_ready one cycle later (LOAD).
  - core_enable rises the cycle after LOAD.
  - resp_valid rises the cycle after core_done.
- Core sequencing:
  - core_enable is low for at least 2 cycles between blocks (RESPOND + IDLE), guaranteeing the controller returns to its idle state.
  - core_data_in=0 outside RUN.
- Ownership and bus values:
  - req_ready and resp_valid are always one-hot or zero, never both nonzero.
  - resp_data=0 outside RESPOND.
  - grant_id holds its last value in IDLE.
- Fairness: a continuously requesting requester waits at most NUM_REQ-1 completed grants.
- Reset mid-operation: the block in flight is discarded; no resp_valid after reset deasserts.

Decomposition:
- Shared package aes_pkg holds:
  - arb_state_t enum (IDLE, LOAD, RUN, RESPOND);
  - AES_BLOCK_W=128;
  - the default timeout constant.
- One natural sub-module, rr_pick: a combinational round-robin selector taking the request vector and pointer and returning a valid flag and index. It is reused by future key-store arbitration.

Test Plan:
- Single request: key 000102..0f in the core model; req_valid[0] with plaintext 00112233445566778899aabbccddeeff -> req_ready[0] pulses 1 cycle later, core_enable rises next cycle, then resp_valid[0] with resp_data=69c4e0d86a7b0430d8cdb78070b4c55a, dropped after resp_ready[0].
- Contention: req_valid=4'b1111 held from reset -> grant order 0,1,2,3,0; after serving 2 with only 2 and 3 requesting, next grant is 3.
- Backpressure: hold resp_ready[1]=0 for 20 cycles -> resp_valid[1] and resp_data stable throughout, core_enable=0, no new req_ready.
- Timeout: core model never asserts done -> timeout_err pulses 64 cycles after RUN entry, no resp_valid, next requester granted; core_done arriving on cycle 64 -> normal response, no timeout_err.
- Withdraw: req_valid[2] dropped in the LOAD cycle -> no RUN, rr_ptr unchanged, requester 2 still first-eligible after 3.
- Reset mid-RUN: n_rst low for 1 cycle -> all outputs 0 immediately, IDLE, next grant goes to requester 0.
